// File: rtl/feedback_arbiter_if.sv
// Feedback path bundle: requester handshakes in, granted note and status out.
// The arbiter takes the slave side; requesters and benches take the master side.
interface feedback_arbiter_if;
    logic       simon_req;
    logic [1:0] simon_num;
    logic       simon_ack;
    logic       player_req;
    logic [1:0] player_num;
    logic       over_req;
    logic [1:0] num;
    logic       pressed;
    logic       busy;
    logic       jingle_done;

    modport master (
        output simon_req, simon_num, player_req, player_num, over_req,
        input  simon_ack, num, pressed, busy, jingle_done
    );

    modport slave (
        input  simon_req, simon_num, player_req, player_num, over_req,
        output simon_ack, num, pressed, busy, jingle_done
    );
endinterface

// File: rtl/feedback_arbiter.sv
// feedback_arbiter: shares the num/pressed LED+tone path between Simon playback,
// the player buttons and the game-over jingle, enforcing a minimum tone length
// and a silent gap after every tone.
// Optional feature macro: FEEDBACK_JINGLE_EN (jingle sequencer and pending flag).
// Without it, over_req only produces a jingle_done pulse on the next cycle.
module feedback_arbiter #(
    parameter int unsigned ON_CYCLES  = 8,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    feedback_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TONE  = 3'd1,
        ST_GAP   = 3'd2,
        ST_JTONE = 3'd3,
        ST_JGAP  = 3'd4
    } state_t;

    localparam logic [23:0] ON_LAST  = 24'(ON_CYCLES - 1);
    localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);

    state_t      state_r, state_s;
    logic [23:0] cnt_r, cnt_s;
    logic        src_simon_r, src_simon_s;
    logic        rearm_r, rearm_s;
    logic        jingle_req_s;
    logic        tone_grant_s, simon_grant_s, player_grant_s;

    logic [1:0]  num_r, num_s;
    logic        pressed_r, pressed_s;
    logic        ack_r, ack_s;
    logic        busy_r, busy_s;
    logic        jdone_r, jdone_s;

`ifdef FEEDBACK_JINGLE_EN
    logic [1:0]  idx_r, idx_s;
    logic        over_pend_r, over_pend_s;
    logic        jingle_start_s;

    assign jingle_req_s   = over_pend_r | bus.over_req;
    assign jingle_start_s = (state_r == ST_IDLE) && (state_s == ST_JTONE);
`else
    assign jingle_req_s   = 1'b0;
`endif

    // A tone grant is the IDLE->TONE step; Simon outranks the player there
    assign tone_grant_s   = (state_r == ST_IDLE) && (state_s == ST_TONE);
    assign simon_grant_s  = tone_grant_s & bus.simon_req;
    assign player_grant_s = tone_grant_s & ~bus.simon_req;

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 24'd0;
            src_simon_r <= 1'b0;
            rearm_r     <= 1'b1;
`ifdef FEEDBACK_JINGLE_EN
            idx_r       <= 2'd0;
            over_pend_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            src_simon_r <= src_simon_s;
            rearm_r     <= rearm_s;
`ifdef FEEDBACK_JINGLE_EN
            idx_r       <= idx_s;
            over_pend_r <= over_pend_s;
`endif
        end
    end

    // Next-state decode: IDLE arbitration, tone/gap timing, jingle sequencing
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (jingle_req_s)                      state_s = ST_JTONE;
                else if (bus.simon_req)                state_s = ST_TONE;
                else if (bus.player_req && rearm_r)    state_s = ST_TONE;
                else                                   state_s = ST_IDLE;
            end
            ST_TONE: begin
                if ((cnt_r == ON_LAST) && (src_simon_r || !bus.player_req)) state_s = ST_GAP;
                else                                                       state_s = ST_TONE;
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) state_s = ST_IDLE;
                else                   state_s = ST_GAP;
            end
`ifdef FEEDBACK_JINGLE_EN
            ST_JTONE: begin
                if (cnt_r == ON_LAST) state_s = ST_JGAP;
                else                  state_s = ST_JTONE;
            end
            ST_JGAP: begin
                if (cnt_r == GAP_LAST) begin
                    if (idx_r == 2'd3) state_s = ST_IDLE;
                    else               state_s = ST_JTONE;
                end else begin
                    state_s = ST_JGAP;
                end
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // Counter (cleared on every state entry, saturating in tones), source and rearm tracking
    always_comb begin
        if (state_s != state_r)                    cnt_s = 24'd0;
        else if (state_r == ST_IDLE)               cnt_s = 24'd0;
        else if (((state_r == ST_TONE) || (state_r == ST_JTONE)) && (cnt_r == ON_LAST))
                                                   cnt_s = cnt_r;
        else                                       cnt_s = cnt_r + 24'd1;

        if (tone_grant_s) src_simon_s = bus.simon_req;
        else              src_simon_s = src_simon_r;

        // A held button must be seen released before it may start another tone
        if (!bus.player_req)    rearm_s = 1'b1;
        else if (player_grant_s) rearm_s = 1'b0;
        else                    rearm_s = rearm_r;

`ifdef FEEDBACK_JINGLE_EN
        if (state_r == ST_IDLE)                              idx_s = 2'd0;
        else if ((state_r == ST_JGAP) && (state_s == ST_JTONE)) idx_s = idx_r + 2'd1;
        else                                                 idx_s = idx_r;

        if (jingle_start_s)    over_pend_s = 1'b0;
        else if (bus.over_req) over_pend_s = 1'b1;
        else                   over_pend_s = over_pend_r;
`endif
    end

    // Next values of the registered outputs
    always_comb begin
        num_s = num_r;
        case (state_s)
            ST_TONE: begin
                if (simon_grant_s)       num_s = bus.simon_num;
                else if (player_grant_s) num_s = bus.player_num;
                else                     num_s = num_r;
            end
`ifdef FEEDBACK_JINGLE_EN
            // Jingle notes run 3,2,1,0 as the index runs 0..3
            ST_JTONE: num_s = ~idx_s;
`endif
            default: num_s = num_r;
        endcase
        pressed_s = (state_s == ST_TONE) || (state_s == ST_JTONE);
        ack_s     = simon_grant_s;
`ifdef FEEDBACK_JINGLE_EN
        busy_s    = (state_s != ST_IDLE) || over_pend_s;
        jdone_s   = (state_r == ST_JGAP) && (state_s == ST_IDLE);
`else
        busy_s    = (state_s != ST_IDLE);
        jdone_s   = bus.over_req;
`endif
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            num_r     <= 2'd0;
            pressed_r <= 1'b0;
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            jdone_r   <= 1'b0;
        end else begin
            num_r     <= num_s;
            pressed_r <= pressed_s;
            ack_r     <= ack_s;
            busy_r    <= busy_s;
            jdone_r   <= jdone_s;
        end
    end

    assign bus.num         = num_r;
    assign bus.pressed     = pressed_r;
    assign bus.simon_ack   = ack_r;
    assign bus.busy        = busy_r;
    assign bus.jingle_done = jdone_r;
endmodule

// File: tb/tb_feedback_arbiter.sv
// Bench for feedback_arbiter: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a segment/queue reference model.
// Follows FEEDBACK_JINGLE_EN the same way the design does.
module tb_feedback_arbiter;
    localparam int ON  = 8;
    localparam int GAP = 4;
`ifdef FEEDBACK_JINGLE_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic clk;
    logic reset;
    feedback_arbiter_if ifc();

    feedback_arbiter #(.ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a tone or silence segment with its elapsed length,
    // plus a queue of jingle notes still to play.
    int         m_kind;      // 0 quiet/idle, 1 sounding, 2 silent gap
    int         m_len;
    bit         m_simon, m_jingle, m_pend, m_rearm;
    logic [1:0] m_notes[$];
    logic [1:0] e_num;
    bit         e_pressed, e_ack, e_busy, e_jdone;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit started;
        bit player_granted;
        started = 1'b0;
        player_granted = 1'b0;
        if (reset) begin
            m_kind = 0; m_len = 0; m_simon = 1'b0; m_jingle = 1'b0;
            m_pend = 1'b0; m_rearm = 1'b1; m_notes.delete();
            e_num = 2'd0; e_pressed = 1'b0; e_ack = 1'b0; e_busy = 1'b0; e_jdone = 1'b0;
            return;
        end
        e_ack = 1'b0;
        e_jdone = 1'b0;
        case (m_kind)
            0: begin
                if (JEN && (m_pend || ifc.over_req)) begin
                    m_jingle = 1'b1; m_notes.delete();
                    m_notes.push_back(2'd2); m_notes.push_back(2'd1); m_notes.push_back(2'd0);
                    e_num = 2'd3; m_kind = 1; m_len = 1; m_pend = 1'b0; started = 1'b1;
                end else if (ifc.simon_req) begin
                    e_num = ifc.simon_num; e_ack = 1'b1; m_simon = 1'b1; m_kind = 1; m_len = 1;
                end else if (ifc.player_req && m_rearm) begin
                    e_num = ifc.player_num; m_simon = 1'b0; m_kind = 1; m_len = 1;
                    player_granted = 1'b1;
                end
            end
            1: begin
                if (m_len >= ON && (m_jingle || m_simon || !ifc.player_req)) begin
                    m_kind = 2; m_len = 1;
                end else begin
                    m_len++;
                end
            end
            default: begin
                if (m_len >= GAP) begin
                    if (m_jingle && m_notes.size() > 0) begin
                        e_num = m_notes.pop_front(); m_kind = 1; m_len = 1;
                    end else begin
                        e_jdone = m_jingle; m_jingle = 1'b0; m_kind = 0; m_len = 0;
                    end
                end else begin
                    m_len++;
                end
            end
        endcase
        if (!ifc.player_req)    m_rearm = 1'b1;
        else if (player_granted) m_rearm = 1'b0;
        if (JEN && ifc.over_req && !started) m_pend = 1'b1;
        if (!JEN) e_jdone = ifc.over_req;
        e_pressed = (m_kind == 1);
        e_busy    = (m_kind != 0) || m_pend;
    endtask

    // One clock: advance the model with the inputs the DUT samples, then compare
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("num",         32'(ifc.num),         32'(e_num));
        check_eq("pressed",     32'(ifc.pressed),     32'(e_pressed));
        check_eq("simon_ack",   32'(ifc.simon_ack),   32'(e_ack));
        check_eq("busy",        32'(ifc.busy),        32'(e_busy));
        check_eq("jingle_done", 32'(ifc.jingle_done), 32'(e_jdone));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hi, lo, n;
        reset = 1'b1;
        ifc.simon_req = 1'b0; ifc.simon_num = 2'd0;
        ifc.player_req = 1'b0; ifc.player_num = 2'd0; ifc.over_req = 1'b0;
        tick();
        tick();
        check_eq("rst_pressed", 32'(ifc.pressed), 32'd0);
        check_eq("rst_busy",    32'(ifc.busy),    32'd0);
        reset = 1'b0;
        tick();

        // Simon: one-cycle grant latency, ON-long tone, GAP+1 quiet, re-grant while held
        ifc.simon_req = 1'b1; ifc.simon_num = 2'd2;
        tick();
        check_eq("simon_ack_lat", 32'(ifc.simon_ack), 32'd1);
        check_eq("simon_num",     32'(ifc.num),       32'd2);
        hi = 0;
        while (ifc.pressed && hi < 100) begin hi++; tick(); end
        check_eq("simon_on_len", 32'(hi), 32'(ON));
        lo = 0;
        while (!ifc.pressed && lo < 100) begin lo++; tick(); end
        check_eq("simon_gap_len", 32'(lo), 32'(GAP + 1));
        check_eq("simon_reack",   32'(ifc.simon_ack), 32'd1);
        ifc.simon_req = 1'b0;
        idle(ON + GAP + 3);

        // Short player tap is stretched to ON cycles
        ifc.player_req = 1'b1; ifc.player_num = 2'd1;
        tick();
        hi = 0;
        while (ifc.pressed && hi < 100) begin
            hi++;
            if (hi == 2) ifc.player_req = 1'b0;
            tick();
        end
        check_eq("tap_len", 32'(hi), 32'(ON));
        idle(GAP + 3);

        // Collision: Simon first, waiting player served after the gap
        ifc.simon_req = 1'b1; ifc.simon_num = 2'd0;
        ifc.player_req = 1'b1; ifc.player_num = 2'd3;
        tick();
        check_eq("coll_ack", 32'(ifc.simon_ack), 32'd1);
        check_eq("coll_num", 32'(ifc.num),       32'd0);
        ifc.simon_req = 1'b0;
        n = 0;
        while (ifc.pressed && n < 100) begin n++; tick(); end
        n = 0;
        while (!ifc.pressed && n < 100) begin n++; tick(); end
        check_eq("coll_gap",        32'(n),       32'(GAP + 1));
        check_eq("coll_player_num", 32'(ifc.num), 32'd3);
        ifc.player_req = 1'b0;
        idle(ON + GAP + 3);

        // Reset in the third cycle of a tone, then a fresh grant
        ifc.simon_req = 1'b1; ifc.simon_num = 2'd1;
        tick();
        ifc.simon_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("mid_rst_pressed", 32'(ifc.pressed), 32'd0);
        check_eq("mid_rst_num",     32'(ifc.num),     32'd0);
        reset = 1'b0;
        ifc.player_req = 1'b1; ifc.player_num = 2'd3;
        tick();
        check_eq("post_rst_grant", 32'(ifc.pressed), 32'd1);
        check_eq("post_rst_num",   32'(ifc.num),     32'd3);
        ifc.player_req = 1'b0;
        idle(ON + GAP + 3);

`ifdef FEEDBACK_JINGLE_EN
        // Jingle requested mid-tone: tone completes, then 4 notes, done after 48 cycles
        ifc.simon_req = 1'b1; ifc.simon_num = 2'd1;
        tick();
        ifc.simon_req = 1'b0;
        tick();
        ifc.over_req = 1'b1;
        tick();
        ifc.over_req = 1'b0;
        check_eq("jg_pend_busy", 32'(ifc.busy), 32'd1);
        n = 0;
        while (!(ifc.pressed && ifc.num == 2'd3) && n < 100) begin n++; tick(); end
        n = 0;
        while (!ifc.jingle_done && n < 200) begin n++; tick(); end
        check_eq("jg_done_delay", 32'(n), 32'(4 * (ON + GAP)));
        idle(4);
`else
        // Jingle disabled: over_req only echoes a done pulse
        ifc.over_req = 1'b1;
        tick();
        ifc.over_req = 1'b0;
        check_eq("nojg_done",    32'(ifc.jingle_done), 32'd1);
        check_eq("nojg_pressed", 32'(ifc.pressed),     32'd0);
        tick();
        check_eq("nojg_done_clr", 32'(ifc.jingle_done), 32'd0);
        idle(2);
`endif

        // Randomized traffic; Simon holds its request until acked
        for (int c = 0; c < 4000; c++) begin
            if (e_ack) begin
                ifc.simon_req = ($urandom_range(0, 3) == 0);
                ifc.simon_num = 2'($urandom_range(0, 3));
            end else if (!ifc.simon_req && $urandom_range(0, 15) == 0) begin
                ifc.simon_req = 1'b1;
                ifc.simon_num = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) ifc.player_req = ~ifc.player_req;
            if ($urandom_range(0, 3) == 0) ifc.player_num = 2'($urandom_range(0, 3));
            ifc.over_req = ($urandom_range(0, 79) == 0);
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
